// File: rtl/agu_lsu_ctrl_if.sv
// Bundle of the AGU issue, data-memory and CDB signals for the load/store controller.
// master is the controller side; slave is the queue/memory/arbiter side.
interface agu_lsu_ctrl_if #(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned XLEN  = 32
);
  logic             issue_valid;
  logic [XLEN-1:0]  ex_address;
  logic [XLEN-1:0]  ex_data;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_tag_valid;
  logic [2:0]       funct3;
  logic             agu_ls;
  logic             ex_done;

  logic             mem_req;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_rdata;

  logic             cdb_req;
  logic             cdb_grant;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_data;

  logic             misalign_err;
  logic [TAG_W-1:0] err_tag;

  modport master (
    input  issue_valid, ex_address, ex_data, rd_tag, rd_tag_valid, funct3, agu_ls,
    output ex_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata,
    output cdb_req, cdb_tag, cdb_data,
    input  cdb_grant,
    output misalign_err, err_tag
  );

  modport slave (
    output issue_valid, ex_address, ex_data, rd_tag, rd_tag_valid, funct3, agu_ls,
    input  ex_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata,
    input  cdb_req, cdb_tag, cdb_data,
    output cdb_grant,
    input  misalign_err, err_tag
  );
endinterface

// File: rtl/agu_lsu_ctrl.sv
// Single-outstanding, in-order load/store sequencer between the AGU queue, data memory
// and CDB. Handles store lane steering, load extraction/extension and misalign drops.
module agu_lsu_ctrl #(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned XLEN  = 32
) (
  input  logic           clk,
  input  logic           rst,
  agu_lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StMem, StCdb} state_e;

  state_e           state_q, state_d;
  logic             cap_q, cap_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             tagv_q, tagv_d;
  logic [2:0]       f3_q, f3_d;
  logic             ls_q, ls_d;
  logic [XLEN-1:0]  cdb_data_q, cdb_data_d;

  logic             legal;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [XLEN-1:0]  load_fmt;

  always_comb begin
    legal = 1'b0;
    case (f3_q)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr_q[0];
      3'b010:  legal = (addr_q[1:0] == 2'b00);
      3'b100:  legal = ~ls_q;
      3'b101:  legal = ~ls_q & ~addr_q[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte  = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half  = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_fmt = bus.mem_rdata;
    case (f3_q)
      3'b000:  load_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: load_fmt = bus.mem_rdata;
    endcase
  end

  // cap_q marks the ex_done cycle; the FSM is still idle but ignores issue_valid then.
  always_comb begin
    state_d    = state_q;
    cap_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    tag_d      = tag_q;
    tagv_d     = tagv_q;
    f3_d       = f3_q;
    ls_d       = ls_q;
    cdb_data_d = cdb_data_q;
    case (state_q)
      StIdle: begin
        if (cap_q) begin
          if (legal) state_d = StMem;
        end else if (bus.issue_valid) begin
          cap_d  = 1'b1;
          addr_d = bus.ex_address;
          data_d = bus.ex_data;
          tag_d  = bus.rd_tag;
          tagv_d = bus.rd_tag_valid;
          f3_d   = bus.funct3;
          ls_d   = bus.agu_ls;
        end
      end
      StMem: begin
        if (bus.mem_ready) begin
          if (!ls_q && tagv_q) begin
            cdb_data_d = load_fmt;
            state_d    = StCdb;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StCdb: begin
        if (bus.cdb_grant) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cap_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tag_q      <= '0;
      tagv_q     <= 1'b0;
      f3_q       <= 3'b000;
      ls_q       <= 1'b0;
      cdb_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tag_q      <= tag_d;
      tagv_q     <= tagv_d;
      f3_q       <= f3_d;
      ls_q       <= ls_d;
      cdb_data_q <= cdb_data_d;
    end
  end

  always_comb begin
    bus.ex_done      = cap_q;
    bus.misalign_err = cap_q & ~legal;
    bus.err_tag      = (cap_q & ~legal) ? tag_q : '0;

    bus.mem_req   = (state_q == StMem);
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'b0000;
    if (state_q == StMem) begin
      bus.mem_we   = ls_q;
      bus.mem_addr = {addr_q[XLEN-1:2], 2'b00};
      bus.mem_be   = 4'b1111;
      if (ls_q) begin
        case (f3_q)
          3'b000: begin
            bus.mem_be    = 4'b0001 << addr_q[1:0];
            bus.mem_wdata = {4{data_q[7:0]}};
          end
          3'b001: begin
            bus.mem_be    = 4'b0011 << {addr_q[1], 1'b0};
            bus.mem_wdata = {2{data_q[15:0]}};
          end
          default: begin
            bus.mem_be    = 4'b1111;
            bus.mem_wdata = data_q;
          end
        endcase
      end
    end

    bus.cdb_req  = (state_q == StCdb);
    bus.cdb_tag  = (state_q == StCdb) ? tag_q : '0;
    bus.cdb_data = (state_q == StCdb) ? cdb_data_q : '0;
  end

endmodule

// File: tb/tb_agu_lsu_ctrl.sv
// Self-checking bench for agu_lsu_ctrl: directed vector table, reset corner cases and
// randomized operations checked against an arithmetic reference model.
module tb_agu_lsu_ctrl;

  localparam int unsigned TAG_W = 6;
  localparam int unsigned XLEN  = 32;

  logic clk;
  logic rst;

  agu_lsu_ctrl_if #(.TAG_W(TAG_W), .XLEN(XLEN)) bus ();

  agu_lsu_ctrl #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [2:0]  f3;
    bit          ls;
    logic [5:0]  tag;
    bit          tagv;
    int          mstall;
    int          gstall;
    bit          hold;
    bit          err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] cdb;
  } vec_t;

  int checks;
  int failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input logic [2:0] f3, input bit ls,
                              input logic [5:0] tag, input bit tagv, input int mstall,
                              input int gstall, input bit hold, input bit err,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input logic [31:0] cdb);
    vec_t v;
    v.addr = addr; v.data = data; v.rdata = rdata; v.f3 = f3; v.ls = ls;
    v.tag = tag; v.tagv = tagv; v.mstall = mstall; v.gstall = gstall; v.hold = hold;
    v.err = err; v.be = be; v.wdata = wdata; v.cdb = cdb;
    return v;
  endfunction

  // Reference: access size from funct3, arithmetic shifts/masks for lanes and extension.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int bytes;
    int off;
    longint unsigned mask;
    longint unsigned val;
    r     = v;
    bytes = 1 << (v.f3 % 4);
    off   = v.addr % 4;
    mask  = (64'd1 << (8 * bytes)) - 64'd1;
    r.err = !((v.f3 <= 2) || (!v.ls && (v.f3 == 4 || v.f3 == 5))) || ((v.addr % bytes) != 0);
    if (v.ls) begin
      r.be    = 4'(((1 << bytes) - 1) << off);
      r.wdata = 32'((longint'(v.data) & mask) *
                    (bytes == 1 ? 64'h01010101 : (bytes == 2 ? 64'h00010001 : 64'd1)));
      r.cdb   = 32'h0;
    end else begin
      r.be    = 4'hF;
      r.wdata = 32'h0;
      val     = (longint'(v.rdata) >> (8 * off)) & mask;
      if (v.f3 < 4 && bytes < 4 && ((val >> (8 * bytes - 1)) & 64'd1) == 64'd1)
        val = val | ~mask;
      r.cdb = val[31:0];
    end
    return r;
  endfunction

  task automatic drive_entry(input vec_t v);
    bus.ex_address   = v.addr;
    bus.ex_data      = v.data;
    bus.rd_tag       = v.tag;
    bus.rd_tag_valid = v.tagv;
    bus.funct3       = v.f3;
    bus.agu_ls       = v.ls;
  endtask

  task automatic scramble_entry();
    bus.ex_address   = $urandom;
    bus.ex_data      = $urandom;
    bus.rd_tag       = 6'($urandom);
    bus.rd_tag_valid = 1'($urandom);
    bus.funct3       = 3'($urandom);
    bus.agu_ls       = 1'($urandom);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ex_done"}, 32'(bus.ex_done), 0);
    chk({pfx, "_mem_req"}, 32'(bus.mem_req), 0);
    chk({pfx, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
    chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({pfx, "_mem_be"}, 32'(bus.mem_be), 0);
    chk({pfx, "_cdb_req"}, 32'(bus.cdb_req), 0);
    chk({pfx, "_cdb_tag"}, 32'(bus.cdb_tag), 0);
    chk({pfx, "_cdb_data"}, bus.cdb_data, 0);
    chk({pfx, "_misalign_err"}, 32'(bus.misalign_err), 0);
    chk({pfx, "_err_tag"}, 32'(bus.err_tag), 0);
  endtask

  // Runs one entry from issue to return-to-idle; starts and ends at a negedge.
  task automatic do_op(input vec_t v);
    bit to_idle_from_mem;
    to_idle_from_mem = v.ls || !v.tagv;
    drive_entry(v);
    bus.issue_valid = 1'b1;
    bus.mem_ready   = 1'b0;
    bus.cdb_grant   = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ex_done_pulse", 32'(bus.ex_done), 1);
    chk("misalign_err", 32'(bus.misalign_err), 32'(v.err));
    if (v.err) chk("err_tag", 32'(bus.err_tag), 32'(v.tag));
    chk("mem_req_in_done", 32'(bus.mem_req), 0);
    chk("cdb_req_in_done", 32'(bus.cdb_req), 0);
    bus.issue_valid = v.hold;
    bus.mem_ready   = 1'b1;
    bus.cdb_grant   = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.cdb_grant = 1'b0;
    if (v.err) begin
      bus.issue_valid = 1'b0;
      chk("err_no_ex_done", 32'(bus.ex_done), 0);
      chk("err_pulse_once", 32'(bus.misalign_err), 0);
      chk("err_no_mem_req", 32'(bus.mem_req), 0);
      chk("err_no_cdb_req", 32'(bus.cdb_req), 0);
      return;
    end
    for (int i = 0; i <= v.mstall; i++) begin
      chk("mem_req", 32'(bus.mem_req), 1);
      chk("mem_we", 32'(bus.mem_we), 32'(v.ls));
      chk("mem_addr", bus.mem_addr, v.addr & 32'hFFFF_FFFC);
      chk("mem_be", 32'(bus.mem_be), 32'(v.be));
      chk("mem_wdata", bus.mem_wdata, v.wdata);
      chk("mem_no_ex_done", 32'(bus.ex_done), 0);
      chk("mem_no_cdb_req", 32'(bus.cdb_req), 0);
      if (v.hold) scramble_entry();
      bus.mem_ready = (i == v.mstall);
      bus.mem_rdata = (i == v.mstall) ? v.rdata : $urandom;
      if (i == v.mstall && to_idle_from_mem) bus.issue_valid = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    chk("mem_req_drop", 32'(bus.mem_req), 0);
    if (to_idle_from_mem) begin
      chk("no_cdb_req", 32'(bus.cdb_req), 0);
      chk("no_ex_done_after_mem", 32'(bus.ex_done), 0);
      return;
    end
    for (int j = 0; j <= v.gstall; j++) begin
      chk("cdb_req", 32'(bus.cdb_req), 1);
      chk("cdb_tag", 32'(bus.cdb_tag), 32'(v.tag));
      chk("cdb_data", bus.cdb_data, v.cdb);
      chk("cdb_no_mem_req", 32'(bus.mem_req), 0);
      chk("cdb_no_ex_done", 32'(bus.ex_done), 0);
      if (v.hold) scramble_entry();
      bus.cdb_grant = (j == v.gstall);
      if (j == v.gstall) bus.issue_valid = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    bus.cdb_grant = 1'b0;
    chk("cdb_req_drop", 32'(bus.cdb_req), 0);
    chk("no_ex_done_after_cdb", 32'(bus.ex_done), 0);
  endtask

  // Stray mem_ready/cdb_grant while idle must not start anything.
  task automatic idle_noise();
    bus.issue_valid = 1'b0;
    bus.mem_ready   = 1'b1;
    bus.cdb_grant   = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_mem_req", 32'(bus.mem_req), 0);
    chk("idle_cdb_req", 32'(bus.cdb_req), 0);
    chk("idle_ex_done", 32'(bus.ex_done), 0);
    bus.mem_ready = 1'b0;
    bus.cdb_grant = 1'b0;
  endtask

  task automatic reset_mid(input bit in_cdb);
    vec_t v;
    v = mk(32'h80, 0, 32'h1122_3344, 3'b010, 1'b0, 6'd9, 1'b1, 0, 0, 1'b0, 1'b0, 4'hF, 0,
           32'h1122_3344);
    drive_entry(v);
    bus.issue_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.issue_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_pre_mem_req", 32'(bus.mem_req), 1);
    if (in_cdb) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = v.rdata;
      @(posedge clk); @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("rst_pre_cdb_req", 32'(bus.cdb_req), 1);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    chk_zero(in_cdb ? "rst_cdb" : "rst_mem");
    @(posedge clk); @(negedge clk);
    chk_zero(in_cdb ? "post_rst_cdb" : "post_rst_mem");
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.issue_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    bus.cdb_grant   = 1'b0;
    bus.mem_rdata   = '0;
    scramble_entry();

    tbl[0]  = mk(32'h100, 0, 32'hDEAD_BEEF, 3'b010, 0, 6'd5, 1, 0, 0, 0, 0, 4'hF, 0,
                 32'hDEAD_BEEF);
    tbl[1]  = mk(32'h203, 0, 32'h80FF_1234, 3'b000, 0, 6'd7, 1, 0, 0, 0, 0, 4'hF, 0,
                 32'hFFFF_FF80);
    tbl[2]  = mk(32'h203, 0, 32'h80FF_1234, 3'b100, 0, 6'd8, 1, 0, 0, 0, 0, 4'hF, 0,
                 32'h0000_0080);
    tbl[3]  = mk(32'h202, 0, 32'h80FF_1234, 3'b001, 0, 6'd10, 1, 0, 0, 0, 0, 4'hF, 0,
                 32'hFFFF_80FF);
    tbl[4]  = mk(32'h301, 32'h0000_00AB, 0, 3'b000, 1, 6'd11, 0, 0, 0, 0, 0, 4'b0010,
                 32'hABAB_ABAB, 0);
    tbl[5]  = mk(32'h302, 32'h0000_1234, 0, 3'b001, 1, 6'd12, 0, 0, 0, 0, 0, 4'b1100,
                 32'h1234_1234, 0);
    tbl[6]  = mk(32'h40, 0, 32'h1357_9BDF, 3'b010, 0, 6'd33, 1, 5, 3, 1, 0, 4'hF, 0,
                 32'h1357_9BDF);
    tbl[7]  = mk(32'h102, 0, 0, 3'b010, 0, 6'd21, 1, 0, 0, 0, 1, 4'hF, 0, 0);
    tbl[8]  = mk(32'h100, 0, 0, 3'b011, 0, 6'd22, 1, 0, 0, 1, 1, 4'hF, 0, 0);
    tbl[9]  = mk(32'h10, 32'hCAFE_F00D, 0, 3'b010, 1, 6'd23, 1, 2, 0, 0, 0, 4'hF,
                 32'hCAFE_F00D, 0);
    tbl[10] = mk(32'h206, 0, 32'h8001_0000, 3'b101, 0, 6'd63, 1, 1, 1, 0, 0, 4'hF, 0,
                 32'h0000_8001);
    tbl[11] = mk(32'h44, 0, 32'h5555_AAAA, 3'b010, 0, 6'd2, 0, 1, 0, 0, 0, 4'hF, 0, 0);
    tbl[12] = mk(32'h50, 32'hFF, 0, 3'b100, 1, 6'd3, 0, 0, 0, 0, 1, 4'hF, 0, 0);
    tbl[13] = mk(32'h301, 32'h1234, 0, 3'b001, 1, 6'd4, 0, 0, 0, 0, 1, 4'hF, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_zero("idle_after_reset");

    for (int k = 0; k < 14; k++) begin
      do_op(tbl[k]);
      if (k % 3 == 0) idle_noise();
    end

    reset_mid(1'b0);
    do_op(tbl[0]);
    reset_mid(1'b1);
    do_op(tbl[0]);

    for (int n = 0; n < 60; n++) begin
      rv.addr   = $urandom;
      if ($urandom_range(0, 1) == 0) rv.addr[1:0] = 2'b00;
      rv.data   = $urandom;
      rv.rdata  = $urandom;
      rv.f3     = 3'($urandom_range(0, 7));
      rv.ls     = 1'($urandom);
      rv.tag    = 6'($urandom);
      rv.tagv   = ($urandom_range(0, 3) != 0);
      rv.mstall = $urandom_range(0, 3);
      rv.gstall = $urandom_range(0, 3);
      rv.hold   = 1'($urandom);
      rv = model(rv);
      do_op(rv);
      if ($urandom_range(0, 3) == 0) idle_noise();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/agu_lsu_ctrl.md
Name: agu_lsu_ctrl

Overview:
Load/store sequencing controller between the AGU reservation queue and the data memory port.
- Accepts one issued AGU entry at a time (computed address, store data, destination tag, funct3, load/store flag) and acknowledges the queue with ex_done.
- Drives a ready/valid-style data-memory handshake and formats the memory data: byte-lane steering for stores, extraction plus sign/zero extension for loads.
- Publishes load results on the CDB through a request/grant handshake with the CDB arbiter.
- Single outstanding operation; strictly in order.

Parameters:
TAG_W, 6, width of rd tag (matches 64-entry tag space)
XLEN, 32, address/data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
issue_valid  in  1  AGU queue head entry is valid
ex_address  in  XLEN  effective address (op1+imm)
ex_data  in  XLEN  store data (op2)
rd_tag  in  TAG_W  destination tag of entry
rd_tag_valid  in  1  entry has a destination (loads)
funct3  in  3  RISC-V load/store width code
agu_ls  in  1  1=store, 0=load
ex_done  out  1  one-cycle pulse: entry consumed, queue may shift it out
mem_req  out  1  memory request valid
mem_we  out  1  1=write
mem_addr  out  XLEN  word-aligned address ({ex_address[XLEN-1:2],2'b00})
mem_wdata  out  XLEN  lane-steered store data
mem_be  out  4  byte enables
mem_ready  in  1  memory accepts/completes request this cycle
mem_rdata  in  XLEN  read word, valid when mem_ready=1 and mem_we=0
cdb_req  out  1  request CDB slot
cdb_grant  in  1  CDB arbiter grant
cdb_tag  out  TAG_W  tag to broadcast
cdb_data  out  XLEN  formatted load result
misalign_err  out  1  one-cycle pulse: misaligned or illegal funct3 access dropped
err_tag  out  TAG_W  tag of faulting entry, valid with misalign_err

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. ex_done, mem_req, mem_we, cdb_req, misalign_err = 0. mem_be=0. All data/addr/tag outputs = 0. Any in-flight operation is abandoned; no ex_done and no CDB request follows.
- States: IDLE, MEM, CDB.

IDLE:
- If issue_valid=1 at posedge, latch all entry fields into capture registers. Next cycle ex_done=1 for exactly one cycle.
- Legal check (on the latched address/funct3):
  - Legal encodings: LB/SB 000 any alignment; LH/SH 001 requires addr[0]=0; LW/SW 010 requires addr[1:0]=00; LBU 100 and LHU 101 are load-only (LHU requires addr[0]=0).
  - Any other funct3/ls combination is illegal.
  - Legal -> MEM.
  - Misaligned/illegal -> remain IDLE. Pulse misalign_err with err_tag=rd_tag in the same cycle as ex_done. No memory access, no CDB.
- issue_valid is ignored outside IDLE. The queue holding the same entry during the ex_done cycle must not cause a re-capture.

MEM:
- mem_req=1, with mem_we, mem_addr, mem_wdata, mem_be stable until mem_ready=1 is sampled.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
- Loads: mem_we=0, mem_be=4'b1111, mem_wdata=0.
- On mem_ready=1 at posedge:
  - Store -> IDLE.
  - Load with rd_tag_valid=0 -> IDLE, result discarded.
  - Load with rd_tag_valid=1 -> register the formatted result into cdb_data, then CDB.
- Load format: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- mem_req drops in the cycle after acceptance. Stall depth is unbounded.

CDB:
- cdb_req=1 with cdb_tag and cdb_data stable until cdb_grant=1 is sampled, then IDLE. cdb_req drops the next cycle.
- cdb_grant while cdb_req=0 is ignored.

Timing and rules:
- Minimum latencies from capture edge:
  - Store: 2 cycles (mem_ready immediate).
  - Load: 3 cycles to cdb_req deassert with immediate grant.
- The next issue is accepted in the cycle the FSM is back in IDLE, so back-to-back operations have a 1-cycle IDLE gap.
- ex_done is never asserted twice per entry.

Test Plan:
- LW: ex_address=0x100, mem_rdata=0xDEADBEEF, mem_ready and cdb_grant immediate -> mem_addr=0x100, be=1111, cdb_tag=rd_tag, cdb_data=0xDEADBEEF; exactly one ex_done pulse.
- LB/LBU: addr=0x203, rdata=0x80FF_1234 -> LB cdb_data=0xFFFFFF80; LBU cdb_data=0x00000080. LH at addr=0x202 -> 0xFFFF80FF.
- SB addr=0x301 data=0x000000AB -> mem_we=1, be=0010, wdata=0xABABABAB, mem_addr=0x300. SH addr=0x302 data=0x1234 -> be=1100, wdata=0x12341234. No cdb_req for stores.
- Stalls: mem_ready held 0 for 5 cycles, then cdb_grant held 0 for 3 cycles -> outputs stable throughout, single CDB transfer, new issue_valid ignored until IDLE.
- LW at addr=0x102 and funct3=011 -> misalign_err pulse with err_tag, ex_done pulse, no mem_req, no cdb_req.
- rst=0 asserted while in MEM and while in CDB -> next cycle all outputs 0 and state IDLE; a subsequent LW completes normally.
